// File: rtl/tx_pkt_cap_100g_pkg.sv
// Shared definitions for the MAC TX packet capture block: FSM encoding,
// speed codes, XGMII control characters and capture buffer geometry.
package tx_pkt_cap_100g_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_CAPT  = 2'd2,
      ST_DONE  = 2'd3
   } cap_state_e;

   localparam logic [2:0] SPD_10G  = 3'b000;
   localparam logic [2:0] SPD_25G  = 3'b001;
   localparam logic [2:0] SPD_40G  = 3'b010;
   localparam logic [2:0] SPD_50G  = 3'b011;
   localparam logic [2:0] SPD_100G = 3'b100;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;

   localparam int CAP_DEPTH = 2048;
   localparam int CAP_AW    = 11;
   localparam int CAP_DW    = 288;

endpackage

// File: rtl/tx_pkt_cap_ram_2kx288.sv
// Capture buffer: simple dual-port 2048 x 288 (ctrl[31:0] above data[255:0]).
// A read of the address being written returns the previous contents.
import tx_pkt_cap_100g_pkg::*;

module tx_pkt_cap_ram_2kx288 (
   input  logic              x_clk,
   input  logic              we,
   input  logic [CAP_AW-1:0] waddr,
   input  logic [CAP_DW-1:0] wdata,
   input  logic [CAP_AW-1:0] raddr,
   output logic [CAP_DW-1:0] rdata
);

   logic [CAP_DW-1:0] mem [CAP_DEPTH];

   always_ff @(posedge x_clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/tx_pkt_cap_100g.sv
// Captures XGMII-style MAC TX words into a 2K-word buffer for bench readback.
//   state | meaning
//   IDLE  | after reset, nothing captured until armed
//   ARMED | waiting for a word carrying a start byte
//   CAPT  | inside a packet, every strobed word is stored
//   DONE  | packet limit or buffer full reached, held until re-armed
import tx_pkt_cap_100g_pkg::*;

module tx_pkt_cap_100g (
   input  logic          x_clk,
   input  logic          reset_,
   input  logic [2:0]    fmac_speed,
   input  logic [255:0]  data_in,
   input  logic [31:0]   ctrl_in,
   input  logic          tb_tx_pkt_cap_en,
   input  logic [15:0]   tb_tx_pkt_cap_max_pkt,
   input  logic [10:0]   tb_tx_pkt_cap_rd_addr,
   output logic [255:0]  tb_tx_pkt_cap_rd_data,
   output logic [31:0]   tb_tx_pkt_cap_rd_ctrl,
   output logic [11:0]   cap_wr_cnt,
   output logic [15:0]   cap_pkt_cnt,
   output logic          cap_busy,
   output logic          cap_done,
   output logic          cap_full,
   output logic [1:0]    cap_err,
   output logic          test
);

   localparam logic [11:0] WR_LAST = 12'(CAP_DEPTH - 1);

   cap_state_e        state;
   logic [1:0]        phase;
   logic [1:0]        slot;
   logic [255:0]      asm_data, asm_data_nxt, stb_data, s1_data;
   logic [31:0]       asm_ctrl, asm_ctrl_nxt, stb_ctrl, s1_ctrl;
   logic              strobe, s1_vld;
   logic              scan_start, scan_close, scan_in_pkt;
   logic [1:0]        scan_err;
   logic              active, wr_en, pkt_inc, last_pkt;
   logic [15:0]       pkt_nxt;
   logic [CAP_DW-1:0] rd_word;

   assign test = 1'b0;

   always_comb begin
      asm_data_nxt = asm_data;
      asm_ctrl_nxt = asm_ctrl;
      asm_data_nxt[64*slot +: 64] = data_in[63:0];
      asm_ctrl_nxt[8*slot +: 8]   = ctrl_in[7:0];
   end

   always_comb begin
      strobe   = 1'b0;
      stb_data = data_in;
      stb_ctrl = ctrl_in;
      case (fmac_speed)
         SPD_100G:         strobe = 1'b1;
         SPD_40G, SPD_50G: strobe = phase[0];
         SPD_25G:          strobe = (phase == 2'd3);
         SPD_10G: begin
            strobe   = (slot == 2'd3);
            stb_data = asm_data_nxt;
            stb_ctrl = asm_ctrl_nxt;
         end
         default:          strobe = 1'b0;
      endcase
   end

   always_ff @(posedge x_clk) begin
      if (!reset_) begin
         phase    <= '0;
         slot     <= '0;
         asm_data <= {32{XGMII_IDLE}};
         asm_ctrl <= '1;
         s1_vld   <= 1'b0;
      end else if (tb_tx_pkt_cap_en) begin
         phase  <= '0;
         slot   <= '0;
         s1_vld <= 1'b0;
      end else begin
         phase  <= phase + 2'd1;
         s1_vld <= strobe;
         if (fmac_speed == SPD_10G) begin
            slot     <= slot + 2'd1;
            asm_data <= asm_data_nxt;
            asm_ctrl <= asm_ctrl_nxt;
         end
      end
   end

   always_ff @(posedge x_clk) begin
      if (strobe) begin
         s1_data <= stb_data;
         s1_ctrl <= stb_ctrl;
      end
   end

   // Walk bytes in lane order so a terminate followed by a start in the same
   // word closes one packet and opens the next.
   always_comb begin
      scan_in_pkt = (state == ST_CAPT);
      scan_start  = 1'b0;
      scan_close  = 1'b0;
      scan_err    = 2'b00;
      for (int i = 0; i < 32; i++) begin
         if (s1_ctrl[i] && s1_data[8*i +: 8] == XGMII_START) begin
            if (scan_in_pkt) scan_err[0] = 1'b1;
            scan_in_pkt = 1'b1;
            scan_start  = 1'b1;
         end else if (s1_ctrl[i] && s1_data[8*i +: 8] == XGMII_TERM) begin
            if (scan_in_pkt) scan_close = 1'b1;
            else             scan_err[1] = 1'b1;
            scan_in_pkt = 1'b0;
         end
      end
   end

   assign active   = s1_vld && !tb_tx_pkt_cap_en && (state == ST_ARMED || state == ST_CAPT);
   assign wr_en    = active && (state == ST_CAPT || scan_start);
   assign pkt_inc  = active && scan_close;
   assign pkt_nxt  = (cap_pkt_cnt == 16'hFFFF) ? cap_pkt_cnt : cap_pkt_cnt + 16'd1;
   assign last_pkt = pkt_inc && (tb_tx_pkt_cap_max_pkt != 16'd0) && (pkt_nxt >= tb_tx_pkt_cap_max_pkt);

   always_ff @(posedge x_clk) begin
      if (!reset_) begin
         state       <= ST_IDLE;
         cap_wr_cnt  <= '0;
         cap_pkt_cnt <= '0;
         cap_err     <= '0;
         cap_full    <= 1'b0;
         cap_busy    <= 1'b0;
         cap_done    <= 1'b0;
      end else if (tb_tx_pkt_cap_en) begin
         state       <= ST_ARMED;
         cap_wr_cnt  <= '0;
         cap_pkt_cnt <= '0;
         cap_err     <= '0;
         cap_full    <= 1'b0;
         cap_busy    <= 1'b1;
         cap_done    <= 1'b0;
      end else if (active) begin
         cap_err <= cap_err | scan_err;
         if (wr_en)   cap_wr_cnt  <= cap_wr_cnt + 12'd1;
         if (pkt_inc) cap_pkt_cnt <= pkt_nxt;
         if (wr_en && cap_wr_cnt == WR_LAST) cap_full <= 1'b1;
         if ((wr_en && cap_wr_cnt == WR_LAST) || last_pkt) begin
            state    <= ST_DONE;
            cap_busy <= 1'b0;
            cap_done <= 1'b1;
         end else if (scan_in_pkt) begin
            state <= ST_CAPT;
         end else begin
            state <= ST_ARMED;
         end
      end
   end

   tx_pkt_cap_ram_2kx288 u_ram (
      .x_clk (x_clk),
      .we    (wr_en),
      .waddr (cap_wr_cnt[CAP_AW-1:0]),
      .wdata ({s1_ctrl, s1_data}),
      .raddr (tb_tx_pkt_cap_rd_addr),
      .rdata (rd_word)
   );

   assign tb_tx_pkt_cap_rd_data = rd_word[255:0];
   assign tb_tx_pkt_cap_rd_ctrl = rd_word[287:256];

endmodule

// File: tb/tb_tx_pkt_cap_100g.sv
// Bench for tx_pkt_cap_100g: directed vector table, hand sequences for
// reset/priority/full/latency corners, and random streams against a packet model.
module tb_tx_pkt_cap_100g;

   localparam logic [7:0] NB = 8'hFF;   // "no byte" marker in the vector table
   localparam logic [2:0] S10 = 3'b000, S25 = 3'b001, S40 = 3'b010, S50 = 3'b011, S100 = 3'b100, SRSV = 3'b101;

   logic          x_clk = 1'b0;
   logic          reset_;
   logic [2:0]    fmac_speed;
   logic [255:0]  data_in;
   logic [31:0]   ctrl_in;
   logic          tb_tx_pkt_cap_en;
   logic [15:0]   tb_tx_pkt_cap_max_pkt;
   logic [10:0]   tb_tx_pkt_cap_rd_addr;
   logic [255:0]  tb_tx_pkt_cap_rd_data;
   logic [31:0]   tb_tx_pkt_cap_rd_ctrl;
   logic [11:0]   cap_wr_cnt;
   logic [15:0]   cap_pkt_cnt;
   logic          cap_busy, cap_done, cap_full;
   logic [1:0]    cap_err;
   logic          test;

   int checks = 0;
   int errors = 0;

   always #5 x_clk = ~x_clk;

   tx_pkt_cap_100g dut (
      .x_clk                 (x_clk),
      .reset_                (reset_),
      .fmac_speed            (fmac_speed),
      .data_in               (data_in),
      .ctrl_in               (ctrl_in),
      .tb_tx_pkt_cap_en      (tb_tx_pkt_cap_en),
      .tb_tx_pkt_cap_max_pkt (tb_tx_pkt_cap_max_pkt),
      .tb_tx_pkt_cap_rd_addr (tb_tx_pkt_cap_rd_addr),
      .tb_tx_pkt_cap_rd_data (tb_tx_pkt_cap_rd_data),
      .tb_tx_pkt_cap_rd_ctrl (tb_tx_pkt_cap_rd_ctrl),
      .cap_wr_cnt            (cap_wr_cnt),
      .cap_pkt_cnt           (cap_pkt_cnt),
      .cap_busy              (cap_busy),
      .cap_done              (cap_done),
      .cap_full              (cap_full),
      .cap_err               (cap_err),
      .test                  (test)
   );

   // Packet-level reference: stream of words -> stored words and status.
   logic [287:0] m_mem [2048];
   int           m_wr, m_pkt;
   logic [1:0]   m_err;
   logic         m_inpkt, m_done, m_full;
   logic [15:0]  m_max;

   task automatic model_arm(input logic [15:0] maxp);
      m_wr = 0; m_pkt = 0; m_err = 2'b00; m_inpkt = 1'b0;
      m_done = 1'b0; m_full = 1'b0; m_max = maxp;
   endtask

   task automatic model_word(input logic [255:0] d, input logic [31:0] c);
      logic keep, closed;
      logic [7:0] b;
      if (m_done) return;
      keep = m_inpkt;
      closed = 1'b0;
      for (int i = 0; i < 32; i++) begin
         b = d[8*i +: 8];
         if (c[i] && b == 8'hFB) begin
            if (m_inpkt) m_err[0] = 1'b1;
            m_inpkt = 1'b1;
            keep = 1'b1;
         end else if (c[i] && b == 8'hFD) begin
            if (m_inpkt) closed = 1'b1;
            else m_err[1] = 1'b1;
            m_inpkt = 1'b0;
         end
      end
      if (keep) begin
         m_mem[m_wr] = {c, d};
         m_wr++;
         if (m_wr == 2048) begin m_full = 1'b1; m_done = 1'b1; end
      end
      if (closed) begin
         if (m_pkt != 65535) m_pkt++;
         if (m_max != 0 && m_pkt >= int'(m_max)) m_done = 1'b1;
      end
   endtask

   task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge x_clk);
      #1;
   endtask

   task automatic drive_idle();
      data_in = {32{8'h07}};
      ctrl_in = '1;
   endtask

   task automatic arm(input logic [15:0] maxp);
      tb_tx_pkt_cap_max_pkt = maxp;
      drive_idle();
      tb_tx_pkt_cap_en = 1'b1;
      tick();
      tb_tx_pkt_cap_en = 1'b0;
      model_arm(maxp);
   endtask

   // Holds one logical word for exactly one strobe period at the current speed.
   task automatic send_word(input logic [255:0] d, input logic [31:0] c);
      case (fmac_speed)
         S100: begin data_in = d; ctrl_in = c; tick(); end
         S40, S50: begin data_in = d; ctrl_in = c; repeat (2) tick(); end
         S25: begin data_in = d; ctrl_in = c; repeat (4) tick(); end
         S10: for (int k = 0; k < 4; k++) begin
            data_in = d; ctrl_in = c;
            data_in[63:0] = d[64*k +: 64];
            ctrl_in[7:0]  = c[8*k +: 8];
            tick();
         end
         default: begin data_in = d; ctrl_in = c; tick(); end
      endcase
      if (fmac_speed <= S100) model_word(d, c);
   endtask

   task automatic settle();
      fmac_speed = SRSV;
      drive_idle();
      repeat (3) tick();
   endtask

   task automatic make_word(input logic [7:0] sp, input logic [7:0] tp,
                            output logic [255:0] d, output logic [31:0] c);
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      c = '0;
      if (sp != NB) begin d[8*sp +: 8] = 8'hFB; c[sp[4:0]] = 1'b1; end
      if (tp != NB) begin d[8*tp +: 8] = 8'hFD; c[tp[4:0]] = 1'b1; end
   endtask

   task automatic rand_word(output logic [255:0] d, output logic [31:0] c);
      int n, pos, kind;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      c = '0;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
         pos = $urandom_range(0, 31);
         kind = $urandom_range(0, 3);
         c[pos] = 1'b1;
         if (kind == 0 || kind == 2) d[8*pos +: 8] = 8'hFB;
         else if (kind == 1) d[8*pos +: 8] = 8'hFD;
      end
   endtask

   task automatic readback(input string nm, input int n);
      for (int a = 0; a < n; a++) begin
         tb_tx_pkt_cap_rd_addr = 11'(a);
         tick();
         chk($sformatf("%s rd%0d", nm, a), {tb_tx_pkt_cap_rd_ctrl, tb_tx_pkt_cap_rd_data}, m_mem[a]);
      end
   endtask

   task automatic chk_status(input string nm, input int ewr, input int epkt, input logic [1:0] eerr,
                             input logic ebusy, input logic edone, input logic efull);
      chk({nm, " wr"}, 288'(cap_wr_cnt), 288'(ewr));
      chk({nm, " pkt"}, 288'(cap_pkt_cnt), 288'(epkt));
      chk({nm, " err"}, 288'(cap_err), 288'(eerr));
      chk({nm, " busy"}, 288'(cap_busy), 288'(ebusy));
      chk({nm, " done"}, 288'(cap_done), 288'(edone));
      chk({nm, " full"}, 288'(cap_full), 288'(efull));
   endtask

   // sp/tp pack byte positions of start/terminate per word as {w4,w3,w2,w1,w0}.
   typedef struct packed {
      logic [2:0]       spd;
      logic [15:0]      maxp;
      logic [2:0]       nw;
      logic [4:0][7:0]  sp;
      logic [4:0][7:0]  tp;
      logic [11:0]      ewr;
      logic [15:0]      epkt;
      logic [1:0]       eerr;
      logic             ebusy;
      logic             edone;
   } vec_t;

   function automatic vec_t mkv(input logic [2:0] spd, input logic [15:0] maxp, input logic [2:0] nw,
                                input logic [39:0] sp, input logic [39:0] tp, input logic [11:0] ewr,
                                input logic [15:0] epkt, input logic [1:0] eerr, input logic ebusy,
                                input logic edone);
      vec_t v;
      v.spd = spd; v.maxp = maxp; v.nw = nw; v.sp = sp; v.tp = tp;
      v.ewr = ewr; v.epkt = epkt; v.eerr = eerr; v.ebusy = ebusy; v.edone = edone;
      return v;
   endfunction

   vec_t vecs [11];

   initial begin
      logic [255:0] d, w0;
      logic [31:0]  c;
      logic [287:0] old0;
      logic [2:0]   spd_list [5];
      logic         full_bad;
      string        nm;

      vecs[0]  = mkv(S100, 0, 3, {NB,NB,NB,NB,8'd0}, {NB,NB,8'd5,NB,NB}, 3, 1, 2'b00, 1, 0);
      vecs[1]  = mkv(S10,  0, 3, {NB,NB,NB,NB,8'd0}, {NB,NB,8'd5,NB,NB}, 3, 1, 2'b00, 1, 0);
      vecs[2]  = mkv(S100, 2, 5, {5{8'd0}}, {5{8'd7}}, 2, 2, 2'b00, 0, 1);
      vecs[3]  = mkv(S100, 0, 1, {NB,NB,NB,NB,NB}, {NB,NB,NB,NB,8'd3}, 0, 0, 2'b10, 1, 0);
      vecs[4]  = mkv(S100, 0, 3, {NB,NB,NB,8'd0,8'd0}, {NB,NB,8'd4,NB,NB}, 3, 1, 2'b01, 1, 0);
      vecs[5]  = mkv(S100, 0, 2, {NB,NB,NB,NB,8'd10}, {NB,NB,NB,8'd1,8'd2}, 2, 1, 2'b10, 1, 0);
      vecs[6]  = mkv(S25,  0, 2, {NB,NB,NB,NB,8'd0}, {NB,NB,NB,8'd9,NB}, 2, 1, 2'b00, 1, 0);
      vecs[7]  = mkv(S40,  0, 1, {NB,NB,NB,NB,8'd3}, {NB,NB,NB,NB,8'd20}, 1, 1, 2'b00, 1, 0);
      vecs[8]  = mkv(S50,  0, 3, {NB,NB,NB,8'd20,8'd0}, {NB,NB,8'd0,8'd4,NB}, 3, 2, 2'b00, 1, 0);
      vecs[9]  = mkv(S100, 0, 4, {NB,NB,8'd1,NB,NB}, {NB,8'd2,NB,NB,NB}, 2, 1, 2'b00, 1, 0);
      vecs[10] = mkv(SRSV, 0, 1, {NB,NB,NB,NB,8'd0}, {NB,NB,NB,NB,8'd5}, 0, 0, 2'b00, 1, 0);

      spd_list[0] = S10; spd_list[1] = S25; spd_list[2] = S40; spd_list[3] = S50; spd_list[4] = S100;

      reset_ = 1'b0;
      fmac_speed = S100;
      tb_tx_pkt_cap_en = 1'b0;
      tb_tx_pkt_cap_max_pkt = '0;
      tb_tx_pkt_cap_rd_addr = '0;
      drive_idle();
      model_arm(0);
      repeat (2) tick();
      chk_status("reset", 0, 0, 2'b00, 0, 0, 0);
      chk("test tie", 288'(test), 288'(0));

      // IDLE ignores traffic until armed
      reset_ = 1'b1;
      make_word(8'd0, NB, d, c);
      data_in = d; ctrl_in = c;
      repeat (3) tick();
      chk_status("idle", 0, 0, 2'b00, 0, 0, 0);

      for (int v = 0; v < 11; v++) begin
         fmac_speed = vecs[v].spd;
         arm(vecs[v].maxp);
         for (int w = 0; w < int'(vecs[v].nw); w++) begin
            make_word(vecs[v].sp[w], vecs[v].tp[w], d, c);
            send_word(d, c);
         end
         settle();
         nm = $sformatf("vec%0d", v);
         chk_status(nm, int'(vecs[v].ewr), int'(vecs[v].epkt), vecs[v].eerr,
                    vecs[v].ebusy, vecs[v].edone, 1'b0);
         readback(nm, int'(vecs[v].ewr));
      end

      // en coincident with a strobed start word at 50G drops the word
      fmac_speed = S50;
      arm(0);
      make_word(8'd0, NB, d, c);
      data_in = d; ctrl_in = c;
      tick();
      tb_tx_pkt_cap_en = 1'b1;
      tick();
      tb_tx_pkt_cap_en = 1'b0;
      settle();
      chk_status("en_prio", 0, 0, 2'b00, 1, 0, 0);

      // reset in the middle of a packet
      fmac_speed = S100;
      arm(0);
      make_word(8'd0, NB, d, c);
      send_word(d, c);
      make_word(NB, NB, d, c);
      send_word(d, c);
      tick();
      chk("midrst pre busy", 288'(cap_busy), 288'(1));
      reset_ = 1'b0;
      tick();
      chk_status("midrst", 0, 0, 2'b00, 0, 0, 0);
      reset_ = 1'b1;
      settle();

      // buffer fill: 2100 words after a start, only 2048 stored
      fmac_speed = S100;
      arm(0);
      full_bad = 1'b0;
      make_word(8'd0, NB, d, c);
      send_word(d, c);
      for (int i = 1; i < 2100; i++) begin
         make_word(NB, NB, d, c);
         send_word(d, c);
         if (cap_full !== (cap_wr_cnt == 12'd2048)) full_bad = 1'b1;
      end
      settle();
      chk("full track", 288'(full_bad), 288'(0));
      chk_status("full", m_wr, m_pkt, m_err, 0, 1, 1);
      chk("full wr2048", 288'(cap_wr_cnt), 288'(2048));
      tb_tx_pkt_cap_rd_addr = 11'd0;
      tick();
      chk("full addr0", {tb_tx_pkt_cap_rd_ctrl, tb_tx_pkt_cap_rd_data}, m_mem[0]);
      tb_tx_pkt_cap_rd_addr = 11'd2047;
      tick();
      chk("full addr2047", {tb_tx_pkt_cap_rd_ctrl, tb_tx_pkt_cap_rd_data}, m_mem[2047]);
      old0 = m_mem[0];

      // write one clock after strobe; read-during-write returns old contents
      fmac_speed = S100;
      arm(0);
      tb_tx_pkt_cap_rd_addr = 11'd0;
      make_word(8'd0, NB, w0, c);
      data_in = w0; ctrl_in = c;
      tick();
      fmac_speed = SRSV;
      drive_idle();
      chk("lat strobe wr", 288'(cap_wr_cnt), 288'(0));
      tick();
      chk("lat write wr", 288'(cap_wr_cnt), 288'(1));
      chk("lat rdw old", {tb_tx_pkt_cap_rd_ctrl, tb_tx_pkt_cap_rd_data}, old0);
      tick();
      chk("lat rd new", {tb_tx_pkt_cap_rd_ctrl, tb_tx_pkt_cap_rd_data}, {c, w0});

      // random streams against the packet model
      for (int r = 0; r < 25; r++) begin
         int nw;
         fmac_speed = spd_list[$urandom_range(0, 4)];
         arm(16'($urandom_range(0, 3)));
         nw = $urandom_range(3, 16);
         for (int w = 0; w < nw; w++) begin
            rand_word(d, c);
            send_word(d, c);
         end
         settle();
         nm = $sformatf("rnd%0d", r);
         chk_status(nm, m_wr, m_pkt, m_err, !m_done, m_done, m_full);
         readback(nm, m_wr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_pkt_cap_100g.md
TX_PKT_CAP_100G -- requirements
Module: tx_pkt_cap_100g

Interface
REQ-001 SHALL have: x_clk  in  1  sole clock.
REQ-002 SHALL have: reset_  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: fmac_speed  in  3  speed select: 000=10G, 001=25G, 010=40G, 011=50G, 100=100G, 101..111=RSVD.
REQ-004 SHALL have: data_in  in  256  MAC TX XGMII-style data, byte n = bits 8n+7:8n.
REQ-005 SHALL have: ctrl_in  in  32  per-byte control flags; bit n qualifies byte n.
REQ-006 SHALL have: tb_tx_pkt_cap_en  in  1  pulse; clear and arm the capture.
REQ-007 SHALL have: tb_tx_pkt_cap_max_pkt  in  16  packet limit; 0 = unlimited.
REQ-008 SHALL have: tb_tx_pkt_cap_rd_addr  in  11  bench read address.
REQ-009 SHALL have: tb_tx_pkt_cap_rd_data / tb_tx_pkt_cap_rd_ctrl  out  256 / 32  captured word readback.
REQ-010 SHALL have: cap_wr_cnt  out  12  words stored, 0..2048.
REQ-011 SHALL have: cap_pkt_cnt  out  16  completed packets.
REQ-012 SHALL have: cap_busy, cap_done, cap_full  out  1 each  status.
REQ-013 SHALL have: cap_err  out  2  sticky; [0] = start without prior terminate, [1] = terminate without start.
REQ-014 SHALL have: test  out  1  tied to 0.

Function
REQ-015 SHALL generate a word strobe as follows: 100G every clock; 40G and 50G every 2nd clock; 25G every 4th clock; RSVD never. Phase counters SHALL clear on tb_tx_pkt_cap_en.
REQ-016 In 10G mode, each clock SHALL load data_in[63:0] / ctrl_in[7:0] into lane slot k of an assembly word (slot 0 = bits 63:0, k = 0..3); the strobe SHALL fire when slot 3 is loaded.
REQ-017 SHALL define a start byte as ctrl=1 with data 8'hFB, and a terminate byte as ctrl=1 with data 8'hFD.
REQ-018 SHALL implement four states: IDLE, ARMED, CAPT and DONE. Reset SHALL enter IDLE.
REQ-019 From any state, tb_tx_pkt_cap_en SHALL clear cap_wr_cnt, cap_pkt_cnt, cap_err and the write address, and SHALL enter ARMED on the next clock.
REQ-020 In ARMED, a strobed word containing a start byte SHALL be written and SHALL move the FSM to CAPT. Other words SHALL be discarded. A terminate byte seen in ARMED SHALL set cap_err[1].
REQ-021 In CAPT, every strobed word SHALL be written. A word containing a terminate byte SHALL increment cap_pkt_cnt.
REQ-022 After that terminate, the FSM SHALL stay in CAPT if a start byte sits at a higher byte index in the same word; otherwise it SHALL return to ARMED.
REQ-023 A start byte in CAPT with no preceding terminate SHALL set cap_err[0]; that byte SHALL be treated as a new packet start.
REQ-024 When cap_pkt_cnt reaches a nonzero tb_tx_pkt_cap_max_pkt, the FSM SHALL go to DONE in the same cycle as the final increment.
REQ-025 When cap_wr_cnt reaches 2048, cap_full SHALL assert and the FSM SHALL go to DONE. No further writes SHALL occur until tb_tx_pkt_cap_en.
REQ-026 DONE SHALL hold until tb_tx_pkt_cap_en.
REQ-027 cap_busy SHALL equal ARMED|CAPT. cap_done SHALL equal DONE.
REQ-028 The RAM write SHALL occur one clock after the strobe. cap_wr_cnt and cap_pkt_cnt SHALL update on that same clock.
REQ-029 tb_tx_pkt_cap_en coincident with a strobe SHALL take priority; that word SHALL be dropped.
REQ-030 Readback latency SHALL be 1 clock. A read to the address being written in the same cycle SHALL return the old data.
REQ-031 cap_pkt_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-032 With reset_=0 at a clock edge:
  - state SHALL be IDLE;
  - counters, write address, 10G slot index and phase counters SHALL be 0;
  - cap_busy, cap_done, cap_full and cap_err SHALL be 0;
  - the assembly word SHALL be all 8'h07 with ctrl all 1.
REQ-033 Reset mid-capture SHALL abandon the packet. RAM contents are not cleared and are undefined.

Structure
REQ-034 A shared package SHALL hold: the FSM state encoding; speed codes; XGMII constants (IDLE 8'h07, START 8'hFB, TERM 8'hFD); depth 2048; address width 11.
REQ-035 Storage SHALL be one sub-module, tx_pkt_cap_ram_2kx288: simple dual-port, 288 bits = data + ctrl, synchronous read on x_clk.

Verification
REQ-036 100G; en, then 3 words (FB in byte 0, body, FD in byte 5) -> cap_wr_cnt=3, cap_pkt_cnt=1, FSM in ARMED, readback of addr 0..2 matches the sent words.
REQ-037 10G; 12 clocks of 64-bit lanes forming 3 words -> 3 packed words written, slot 0 at bits 63:0, cap_wr_cnt=3.
REQ-038 100G; max_pkt=2, 5 back-to-back single-word packets -> cap_pkt_cnt=2, cap_done=1, cap_wr_cnt=2.
REQ-039 100G; continuous stream of 2100 non-idle words after a start -> cap_full=1 at cap_wr_cnt=2048, no write at addr wrap.
REQ-040 FD with no prior FB -> cap_err=2'b10. FB, FB, FD -> cap_err=2'b01, cap_pkt_cnt=1.
REQ-041 en on the same clock as a strobed FB word at 50G -> word dropped, cap_wr_cnt=0. Reset mid-packet -> IDLE, all status 0.
